// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding decode. Generates sequential word-aligned
// PCs, keeps at most one request outstanding to instruction memory, and
// buffers each returned word together with its PC and an access-fault flag
// in a small circular queue. Decode drains the queue over a valid/ready
// handshake. A redirect flushes the queue and restarts fetch at a new PC.
//
// Parameters
//   RESET_PC     PC loaded on reset (low two bits are ignored)
//   QUEUE_DEPTH  instruction queue entries (power of two, >= 2)
//
// Ports
//   clk_i             clock, all state on rising edge
//   rst_i             asynchronous reset, active-high
//   imem_req_o        memory request valid (held until ack)
//   imem_addr_o       request address, word aligned (held until ack)
//   imem_ack_i        response valid for the current request
//   imem_data_i       instruction word, valid with ack
//   imem_err_i        access fault, valid with ack
//   redirect_i        flush queue and restart fetch
//   redirect_pc_i     new fetch PC
//   id_valid_o        queue head valid
//   id_ready_i        decode accepts the head entry
//   id_instruction_o  head instruction word
//   id_pc_o           head PC
//   id_fault_o        head entry is an access-fault entry
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        imem_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instruction_o,
  output logic [31:0] id_pc_o,
  output logic        id_fault_o
);

  localparam int               PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam logic [31:0]      NOP_INSN   = 32'h0000_0013;
  localparam logic [31:0]      RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH,
    S_FULL,
    S_HALT,
    S_DISCARD
  } state_t;

  // Control state
  state_t            r_state;
  logic              r_req;
  logic [31:0]       r_addr;
  logic [31:0]       r_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  // Queue storage (not reset; outputs are masked while the queue is empty)
  logic [31:0]       r_q_pc    [QUEUE_DEPTH];
  logic [31:0]       r_q_data  [QUEUE_DEPTH];
  logic              r_q_fault [QUEUE_DEPTH];

  // Combinational next-state
  state_t            w_state_nxt;
  logic [31:0]       w_pc_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [31:0]       w_redirect_pc;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;

  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_valid       = (r_count != '0);

  // A response only counts while our request is actually on the bus.
  assign w_fire = r_req & imem_ack_i;

  // Responses are written only in FETCH; in DISCARD (or when a redirect
  // arrives in the same cycle) the returned word belongs to a dead path.
  assign w_push = w_fire & (r_state == S_FETCH) & ~redirect_i;
  assign w_pop  = w_valid & id_ready_i;

  always_comb begin
    if (redirect_i) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (redirect_i) begin
      w_pc_nxt = w_redirect_pc;
      // An unacknowledged request must still complete before the new
      // address can be presented, so wait it out in DISCARD.
      if (r_req && !imem_ack_i) begin
        w_state_nxt = S_DISCARD;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fire) begin
            if (imem_err_i) begin
              w_state_nxt = S_HALT;
            end else begin
              w_pc_nxt = r_pc + 32'd4;
              // Request only when the entry it will fill is free.
              w_state_nxt = (w_count_nxt < DEPTH_C) ? S_FETCH : S_FULL;
            end
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt = S_FETCH;
          end
        end
        S_HALT: begin
          w_state_nxt = S_HALT;
        end
        S_DISCARD: begin
          if (w_fire) begin
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // FSM, request register and queue pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC_A;
      r_addr   <= RESET_PC_A;
      r_req    <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_req   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DISCARD);
      // DISCARD keeps the old address on the bus until its ack arrives.
      if (w_state_nxt == S_FETCH) begin
        r_addr <= w_pc_nxt;
      end
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Queue write port; faulting fetches carry a NOP so decode sees a
  // harmless word alongside the fault flag.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_pc;
      r_q_data[r_wr_ptr]  <= imem_err_i ? NOP_INSN : imem_data_i;
      r_q_fault[r_wr_ptr] <= imem_err_i;
    end
  end

  assign imem_req_o       = r_req;
  assign imem_addr_o      = r_addr;
  assign id_valid_o       = w_valid;
  assign id_instruction_o = w_valid ? r_q_data[r_rd_ptr]  : 32'h0;
  assign id_pc_o          = w_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
  assign id_fault_o       = w_valid ? r_q_fault[r_rd_ptr] : 1'b0;

  // The request rule guarantees a free slot for every accepted response.
  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i) w_push |-> (r_count != DEPTH_C)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i  = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        imem_err_i  = 1'b0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instruction_o;
  logic [31:0] id_pc_o;
  logic        id_fault_o;

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ack_i       (imem_ack_i),
    .imem_data_i      (imem_data_i),
    .imem_err_i       (imem_err_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instruction_o (id_instruction_o),
    .id_pc_o          (id_pc_o),
    .id_fault_o       (id_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
  } ent_t;

  logic [31:0] exp_addr_q [$];
  ent_t        exp_id_q   [$];

  int n_checks = 0;
  int n_errors = 0;

  // Memory model knobs
  int          acks_left = 0;
  int          mem_lat   = 0;
  int          wcnt      = 0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic exp_ent(input logic [31:0] pc, input logic [31:0] ins, input logic f);
    ent_t e;
    e.pc  = pc;
    e.ins = ins;
    e.f   = f;
    exp_id_q.push_back(e);
  endtask

  // Memory: acks after mem_lat wait cycles, limited to acks_left responses;
  // data is the bitwise inverse of the address.
  always @(negedge clk_i) begin
    if (imem_req_o && !rst_i && acks_left > 0) begin
      if (wcnt >= mem_lat) begin
        imem_ack_i  = 1'b1;
        imem_err_i  = err_en && (imem_addr_o == err_addr);
        imem_data_i = imem_err_i ? 32'hDEAD_BEEF : ~imem_addr_o;
        acks_left   = acks_left - 1;
        wcnt        = 0;
      end else begin
        imem_ack_i = 1'b0;
        imem_err_i = 1'b0;
        wcnt       = wcnt + 1;
      end
    end else begin
      imem_ack_i = 1'b0;
      imem_err_i = 1'b0;
      wcnt       = 0;
    end
  end

  // Request monitor: address order and hold-until-ack.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk_i) begin
    logic [31:0] ea;
    #3;
    if (!rst_i && !prev_rst && prev_req && !prev_ack) begin
      chk("req_hold", 32'(imem_req_o), 32'h1);
      chk("addr_hold", imem_addr_o, prev_addr);
    end
    if (!rst_i && imem_req_o && imem_ack_i) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL req_unexpected actual=%h required=none", imem_addr_o);
      end else begin
        ea = exp_addr_q.pop_front();
        chk("req_addr", imem_addr_o, ea);
      end
    end
    prev_req  = imem_req_o;
    prev_ack  = imem_ack_i;
    prev_rst  = rst_i;
    prev_addr = imem_addr_o;
  end

  // Decode-side monitor: compare every accepted head entry.
  always @(negedge clk_i) begin
    ent_t e;
    #3;
    if (!rst_i && id_valid_o && id_ready_i) begin
      if (exp_id_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL id_unexpected actual=%h required=none", id_pc_o);
      end else begin
        e = exp_id_q.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_instr", id_instruction_o, e.ins);
        chk("id_fault", 32'(id_fault_o), 32'(e.f));
      end
    end
  end

  initial begin
    rst_i         = 1'b0;
    id_ready_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #1 rst_i = 1'b1;
    step();
    step();
    #1;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_valid", 32'(id_valid_o), 32'h0);
    chk("rst_instr", id_instruction_o, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_fault", 32'(id_fault_o), 32'h0);

    // Sequential fetch, zero-wait memory
    step();
    rst_i = 1'b0;
    acks_left = 3;
    exp_addr_q.push_back(32'h8000_0000);
    exp_addr_q.push_back(32'h8000_0004);
    exp_addr_q.push_back(32'h8000_0008);
    exp_ent(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    exp_ent(32'h8000_0004, 32'h7FFF_FFFB, 1'b0);
    exp_ent(32'h8000_0008, 32'h7FFF_FFF7, 1'b0);
    step();
    #1;
    chk("first_req", 32'(imem_req_o), 32'h1);
    chk("first_addr", imem_addr_o, 32'h8000_0000);
    step();
    #1;
    chk("first_valid", 32'(id_valid_o), 32'h1);
    chk("first_id_pc", id_pc_o, 32'h8000_0000);
    repeat (6) step();
    #1;
    chk("seq_stall_req", 32'(imem_req_o), 32'h1);
    chk("seq_stall_addr", imem_addr_o, 32'h8000_000C);
    chk("seq_drained", 32'(id_valid_o), 32'h0);

    // Queue fills with decode stalled
    step();
    id_ready_i = 1'b0;
    acks_left = 3;
    exp_addr_q.push_back(32'h8000_000C);
    exp_addr_q.push_back(32'h8000_0010);
    exp_ent(32'h8000_000C, 32'h7FFF_FFF3, 1'b0);
    exp_ent(32'h8000_0010, 32'h7FFF_FFEF, 1'b0);
    repeat (4) step();
    #1;
    chk("full_req", 32'(imem_req_o), 32'h0);
    chk("full_valid", 32'(id_valid_o), 32'h1);
    chk("full_head_pc", id_pc_o, 32'h8000_000C);
    repeat (2) step();
    #1;
    chk("full_req_held", 32'(imem_req_o), 32'h0);
    step();
    id_ready_i = 1'b1;
    exp_addr_q.push_back(32'h8000_0014);
    exp_ent(32'h8000_0014, 32'h7FFF_FFEB, 1'b0);
    step();
    id_ready_i = 1'b0;
    #1;
    chk("resume_req", 32'(imem_req_o), 32'h1);
    chk("resume_addr", imem_addr_o, 32'h8000_0014);
    repeat (3) step();
    #1;
    chk("refull_req", 32'(imem_req_o), 32'h0);
    step();
    id_ready_i = 1'b1;
    repeat (4) step();
    #1;
    chk("drain_valid", 32'(id_valid_o), 32'h0);
    chk("drain_addr", imem_addr_o, 32'h8000_0018);

    // Redirect while a slow request is outstanding
    step();
    mem_lat = 3;
    acks_left = 1;
    exp_addr_q.push_back(32'h8000_0018);
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_1002;
    step();
    redirect_i = 1'b0;
    #1;
    chk("disc_req", 32'(imem_req_o), 32'h1);
    chk("disc_addr", imem_addr_o, 32'h8000_0018);
    chk("disc_valid", 32'(id_valid_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("disc_valid_loop", 32'(id_valid_o), 32'h0);
    end
    chk("disc_new_req", 32'(imem_req_o), 32'h1);
    chk("disc_new_addr", imem_addr_o, 32'h0000_1000);
    step();
    mem_lat = 0;
    acks_left = 2;
    exp_addr_q.push_back(32'h0000_1000);
    exp_addr_q.push_back(32'h0000_1004);
    exp_ent(32'h0000_1000, 32'hFFFF_EFFF, 1'b0);
    exp_ent(32'h0000_1004, 32'hFFFF_EFFB, 1'b0);
    repeat (6) step();

    // Access fault halts fetch until redirect
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0000;
    acks_left = 3;
    err_en = 1'b1;
    err_addr = 32'h8000_0004;
    exp_addr_q.push_back(32'h0000_1008);
    exp_addr_q.push_back(32'h8000_0000);
    exp_addr_q.push_back(32'h8000_0004);
    exp_ent(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    exp_ent(32'h8000_0004, 32'h0000_0013, 1'b1);
    step();
    redirect_i = 1'b0;
    repeat (5) step();
    #1;
    chk("halt_req", 32'(imem_req_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("halt_req_loop", 32'(imem_req_o), 32'h0);
    end
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    acks_left = 1;
    err_en = 1'b0;
    exp_addr_q.push_back(32'h8000_0100);
    exp_ent(32'h8000_0100, 32'h7FFF_FEFF, 1'b0);
    step();
    redirect_i = 1'b0;
    #1;
    chk("halt_exit_req", 32'(imem_req_o), 32'h1);
    chk("halt_exit_addr", imem_addr_o, 32'h8000_0100);
    repeat (4) step();

    // PC wrap at the top of the address space
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    acks_left = 3;
    exp_addr_q.push_back(32'h8000_0104);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_ent(32'hFFFF_FFFC, 32'h0000_0003, 1'b0);
    exp_ent(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    redirect_i = 1'b0;
    repeat (6) step();
    #1;
    chk("wrap_req", 32'(imem_req_o), 32'h1);
    chk("wrap_addr", imem_addr_o, 32'h0000_0004);

    // Reset with an entry queued and a request pending
    step();
    id_ready_i = 1'b0;
    acks_left = 1;
    exp_addr_q.push_back(32'h0000_0004);
    step();
    step();
    #1;
    chk("pre_rst_valid", 32'(id_valid_o), 32'h1);
    chk("pre_rst_pc", id_pc_o, 32'h0000_0004);
    chk("pre_rst_instr", id_instruction_o, 32'hFFFF_FFFB);
    chk("pre_rst_addr", imem_addr_o, 32'h0000_0008);
    step();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 32'h0);
    chk("mid_rst_valid", 32'(id_valid_o), 32'h0);
    chk("mid_rst_pc", id_pc_o, 32'h0);
    chk("mid_rst_instr", id_instruction_o, 32'h0);
    chk("mid_rst_fault", 32'(id_fault_o), 32'h0);
    step();
    step();
    rst_i = 1'b0;
    id_ready_i = 1'b1;
    acks_left = 1;
    exp_addr_q.push_back(32'h8000_0000);
    exp_ent(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    step();
    #1;
    chk("rel_req", 32'(imem_req_o), 32'h1);
    chk("rel_addr", imem_addr_o, 32'h8000_0000);

    for (int i = 0; i < 20 && (exp_addr_q.size() != 0 || exp_id_q.size() != 0); i++) begin
      step();
    end
    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
    chk("id_q_empty", 32'(exp_id_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and the immediate generator.
- Generates sequential PCs, issues single-outstanding requests to instruction memory, and buffers returned words with their PCs in a small queue.
- Presents queue entries to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump/trap) with flush and access-fault tagging.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0.
QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous reset, active-high
imem_req_o  output  1  memory request valid
imem_addr_o  output  32  request address (word aligned)
imem_ack_i  input  1  response valid for current request
imem_data_i  input  32  instruction word, valid with ack
imem_err_i  input  1  access fault, valid with ack
redirect_i  input  1  flush and restart fetch
redirect_pc_i  input  32  new fetch PC
id_valid_o  output  1  queue head valid
id_ready_i  input  1  decode accepts head
id_instruction_o  output  32  head instruction word
id_pc_o  output  32  head PC
id_fault_o  output  1  head is an access-fault entry

Behaviour:
- Reset, asynchronous:
  - pc = RESET_PC; queue empty; state FETCH.
  - imem_req_o = 0, id_valid_o = 0, id_instruction_o = 0, id_pc_o = 0, id_fault_o = 0.
  - First request is issued in the first cycle after rst_i deasserts.
- Memory protocol:
  - At most one outstanding request.
  - imem_req_o and imem_addr_o are held stable from assertion until the cycle imem_ack_i = 1.
  - Same-cycle ack is legal.
  - imem_req_o is asserted only when (count + 1) <= QUEUE_DEPTH, counting the entry the request will fill.
- States:
  - FETCH: req = 1, addr = pc.
    - On ack with err = 0: push {pc, data, 0}; pc += 4 (wraps modulo 2^32); stay in FETCH if space remains after the push, else go to FULL.
    - On ack with err = 1: push {pc, 32'h0000_0013, 1} and go to HALT.
  - FULL: req = 0. Return to FETCH the cycle after a pop frees an entry.
  - HALT: req = 0. Left only on redirect.
  - DISCARD: req held with the old address; on ack, drop data/err, then go to FETCH at the new pc.
- Redirect (highest priority):
  - Queue is flushed (count = 0) at the next edge; pc = {redirect_pc_i[31:2], 2'b00}.
  - If a request is outstanding and not acked in the same cycle: go to DISCARD.
  - If it is acked in the same cycle: its data is dropped and the next state is FETCH.
  - A redirect while in DISCARD updates pc; the state stays DISCARD.
- Queue:
  - Circular buffer with rd/wr pointers and a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when id_valid_o & id_ready_i.
  - id_valid_o = (count != 0). id_* outputs are driven from the head entry and are not masked by redirect_i.
  - No push when full; this is guaranteed by the request rule and asserted in simulation.
- Latency:
  - With a same-cycle-ack memory and id_ready_i = 1: first id_valid_o one cycle after the first ack; steady state is one instruction per cycle.
  - After a redirect (no outstanding request), first new request the next cycle.

Test Plan:
- Reset release, zero-wait memory, id_ready_i = 1 -> addresses 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; id_pc_o follows one cycle after each ack; id_instruction_o matches memory contents.
- id_ready_i = 0, DEPTH = 2 -> exactly 2 acks accepted, then imem_req_o = 0 (FULL); assert id_ready_i for one cycle -> one pop, req resumes next cycle at 8000_0008.
- Memory with 3-cycle ack latency; redirect_i with redirect_pc_i = 0000_1002 in cycle 1 of the wait -> addr stays 8000_0000 until ack, data discarded, next request to 0000_1000, id_valid_o = 0 throughout.
- Ack with imem_err_i = 1 at 8000_0004 -> entry id_pc_o = 8000_0004, id_fault_o = 1, id_instruction_o = 0000_0013; no further requests until redirect to 8000_0100, after which fetch resumes there.
- pc = FFFF_FFFC, sequential fetch -> next address 0000_0000.
- rst_i asserted mid-request (ack pending) -> outputs clear immediately; first request after release at RESET_PC.
